// File: rtl/tl_tracker_pkg.sv
// Shared types and constants for the TileLink in-flight tracker.
package tl_tracker_pkg;

    // Per-source-ID state
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PEND = 1'b1
    } slot_state_e;

    // Error reporting priority for err_source (lower value wins)
    localparam int unsigned ERR_PRIO_ORPHAN  = 0;
    localparam int unsigned ERR_PRIO_DUP     = 1;
    localparam int unsigned ERR_PRIO_TIMEOUT = 2;
    localparam int unsigned ERR_KINDS        = 3;

    // Watchdog age counter width
    localparam int unsigned AGE_W = 16;

endpackage

// File: rtl/tl_inflight_slot.sv
// One source-ID tracker: IDLE/PEND FSM, beat counter and optional watchdog.
// Watchdog built only when TL_TRACKER_WATCHDOG_EN is defined.
module tl_inflight_slot
    import tl_tracker_pkg::*;
#(
    parameter int unsigned BEAT_W  = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              a_fire,
    input  logic [BEAT_W-1:0] a_beats,
    input  logic              d_fire,
    output logic              pend,
    output logic              dup_c,
    output logic              orphan_c,
    output logic              timeout_c
);

    slot_state_e       state_q, state_d;
    logic [BEAT_W-1:0] cnt_q, cnt_d;
    logic [BEAT_W-1:0] rem_q, rem_d;
    logic              final_beat;

    assign pend       = (state_q == PEND);
    assign final_beat = d_fire && (cnt_q == rem_q);

    // Next-state, counter and error decode
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        dup_c    = 1'b0;
        orphan_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (d_fire) orphan_c = 1'b1;
                if (a_fire) begin
                    state_d = PEND;
                    rem_d   = a_beats;
                    cnt_d   = '0;
                end
            end
            PEND: begin
                if (a_fire && final_beat) begin
                    // Back-to-back reuse of the ID: reload, no error
                    rem_d = a_beats;
                    cnt_d = '0;
                end else begin
                    if (a_fire) dup_c = 1'b1;
                    if (final_beat)  state_d = IDLE;
                    else if (d_fire) cnt_d   = cnt_q + BEAT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and counter registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
        end
    end

`ifdef TL_TRACKER_WATCHDOG_EN
    logic [AGE_W-1:0] age_q, age_d;

    // Age counter: cleared on entry, exit and D beats; saturates at TIMEOUT
    always_comb begin
        age_d = age_q;
        if (state_q == IDLE || state_d == IDLE || d_fire) begin
            age_d = '0;
        end else if (age_q != AGE_W'(TIMEOUT)) begin
            age_d = age_q + AGE_W'(1);
        end
        timeout_c = (age_d == AGE_W'(TIMEOUT)) && (age_q != AGE_W'(TIMEOUT));
    end

    // Age register
    always_ff @(posedge clock) begin
        if (!reset_n) age_q <= '0;
        else          age_q <= age_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^AGE_W'(TIMEOUT);
    assign timeout_c      = 1'b0;
`endif

endmodule

// File: rtl/tl_inflight_tracker.sv
// TileLink in-flight tracker: per-source-ID outstanding bitmap and protocol
// error detection. Optional watchdog enabled by TL_TRACKER_WATCHDOG_EN.
module tl_inflight_tracker
    import tl_tracker_pkg::*;
#(
    parameter int unsigned SOURCE_W = 1,
    parameter int unsigned BEAT_W   = 2,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   a_valid,
    input  logic                   a_ready,
    input  logic [SOURCE_W-1:0]    a_source,
    input  logic [BEAT_W-1:0]      a_beats,
    input  logic                   d_valid,
    input  logic                   d_ready,
    input  logic [SOURCE_W-1:0]    d_source,
    output logic [2**SOURCE_W-1:0] inflight,
    output logic                   err_dup_a,
    output logic                   err_orphan_d,
    output logic                   err_timeout,
    output logic                   err_sticky,
    output logic [SOURCE_W-1:0]    err_source
);

    localparam int unsigned NUM_ID = 2 ** SOURCE_W;

    logic              a_fire, d_fire;
    logic [NUM_ID-1:0] dup_vec, orphan_vec, timeout_vec;
    logic [NUM_ID-1:0] kind_vec [ERR_KINDS];

    logic                err_dup_a_q, err_dup_a_d;
    logic                err_orphan_d_q, err_orphan_d_d;
    logic                err_timeout_q, err_timeout_d;
    logic                err_sticky_q, err_sticky_d;
    logic [SOURCE_W-1:0] err_source_q, err_source_d;

    assign a_fire = a_valid && a_ready;
    assign d_fire = d_valid && d_ready;

    // One tracker slot per source ID
    for (genvar i = 0; i < NUM_ID; i++) begin : g_slot
        tl_inflight_slot #(
            .BEAT_W  (BEAT_W),
            .TIMEOUT (TIMEOUT)
        ) u_slot (
            .clock     (clock),
            .reset_n   (reset_n),
            .a_fire    (a_fire && (a_source == SOURCE_W'(i))),
            .a_beats   (a_beats),
            .d_fire    (d_fire && (d_source == SOURCE_W'(i))),
            .pend      (inflight[i]),
            .dup_c     (dup_vec[i]),
            .orphan_c  (orphan_vec[i]),
            .timeout_c (timeout_vec[i])
        );
    end

    // Error pulses, sticky flag and prioritised source encode
    always_comb begin
        logic found;
        err_dup_a_d    = |dup_vec;
        err_orphan_d_d = |orphan_vec;
        err_timeout_d  = |timeout_vec;
        err_sticky_d   = err_sticky_q | err_dup_a_d | err_orphan_d_d | err_timeout_d;
        err_source_d   = err_source_q;
        found          = 1'b0;
        kind_vec[ERR_PRIO_ORPHAN]  = orphan_vec;
        kind_vec[ERR_PRIO_DUP]     = dup_vec;
        kind_vec[ERR_PRIO_TIMEOUT] = timeout_vec;
        for (int unsigned p = 0; p < ERR_KINDS; p++) begin
            for (int unsigned i = 0; i < NUM_ID; i++) begin
                if (!found && kind_vec[p][i]) begin
                    found        = 1'b1;
                    err_source_d = SOURCE_W'(i);
                end
            end
        end
    end

    // Error output registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            err_dup_a_q    <= 1'b0;
            err_orphan_d_q <= 1'b0;
            err_timeout_q  <= 1'b0;
            err_sticky_q   <= 1'b0;
            err_source_q   <= '0;
        end else begin
            err_dup_a_q    <= err_dup_a_d;
            err_orphan_d_q <= err_orphan_d_d;
            err_timeout_q  <= err_timeout_d;
            err_sticky_q   <= err_sticky_d;
            err_source_q   <= err_source_d;
        end
    end

    assign err_dup_a    = err_dup_a_q;
    assign err_orphan_d = err_orphan_d_q;
    assign err_timeout  = err_timeout_q;
    assign err_sticky   = err_sticky_q;
    assign err_source   = err_source_q;

endmodule

// File: tb/tb_tl_inflight_tracker.sv
// Self-checking bench for tl_inflight_tracker: directed scenarios followed by
// random traffic, compared every cycle against a transaction-level model.
module tb_tl_inflight_tracker;

    localparam int unsigned SW  = 1;
    localparam int unsigned NID = 2 ** SW;
    localparam int unsigned BW  = 2;
    localparam int unsigned TO  = 8;

    logic           clock = 1'b0;
    logic           reset_n;
    logic           a_valid, a_ready, d_valid, d_ready;
    logic [SW-1:0]  a_source, d_source;
    logic [BW-1:0]  a_beats;
    logic [NID-1:0] inflight;
    logic           err_dup_a, err_orphan_d, err_timeout, err_sticky;
    logic [SW-1:0]  err_source;

    int checks = 0;
    int errors = 0;

    // Reference model: per-ID pending flag, D beats still owed, age in cycles
    bit             m_pend [NID];
    int             m_left [NID];
    int             m_age  [NID];
    bit             m_dup, m_orphan, m_tmo, m_sticky;
    int             m_src;

    tl_inflight_tracker #(
        .SOURCE_W (SW),
        .BEAT_W   (BW),
        .TIMEOUT  (TO)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .a_valid      (a_valid),
        .a_ready      (a_ready),
        .a_source     (a_source),
        .a_beats      (a_beats),
        .d_valid      (d_valid),
        .d_ready      (d_ready),
        .d_source     (d_source),
        .inflight     (inflight),
        .err_dup_a    (err_dup_a),
        .err_orphan_d (err_orphan_d),
        .err_timeout  (err_timeout),
        .err_sticky   (err_sticky),
        .err_source   (err_source)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NID-1:0] model_inflight();
        logic [NID-1:0] v = '0;
        for (int i = 0; i < NID; i++) v[i] = m_pend[i];
        return v;
    endfunction

    // Apply one clock of protocol rules to the model
    task automatic model_step(input bit rst, input bit af, input int as, input int ab,
                              input bit df, input int ds);
        bit dup_v [NID];
        bit orp_v [NID];
        bit tmo_v [NID];
        int pick;
        if (!rst) begin
            for (int i = 0; i < NID; i++) begin
                m_pend[i] = 0; m_left[i] = 0; m_age[i] = 0;
            end
            m_dup = 0; m_orphan = 0; m_tmo = 0; m_sticky = 0; m_src = 0;
            return;
        end
        for (int i = 0; i < NID; i++) begin
            bit a = af && (as == i);
            bit d = df && (ds == i);
            dup_v[i] = 0; orp_v[i] = 0; tmo_v[i] = 0;
            if (!m_pend[i]) begin
                if (d) orp_v[i] = 1;
                if (a) begin
                    m_pend[i] = 1; m_left[i] = ab + 1; m_age[i] = 0;
                end
            end else begin
                bit last = d && (m_left[i] == 1);
                if (d) begin
                    m_left[i]--;
                    m_age[i] = 0;
                    if (m_left[i] == 0) m_pend[i] = 0;
                end
                if (a) begin
                    if (last) begin
                        m_pend[i] = 1; m_left[i] = ab + 1; m_age[i] = 0;
                    end else begin
                        dup_v[i] = 1;
                    end
                end
`ifdef TL_TRACKER_WATCHDOG_EN
                if (!d && m_pend[i] && m_age[i] < TO) begin
                    m_age[i]++;
                    if (m_age[i] == TO) tmo_v[i] = 1;
                end
`endif
            end
        end
        m_dup = 0; m_orphan = 0; m_tmo = 0;
        for (int i = 0; i < NID; i++) begin
            m_dup    |= dup_v[i];
            m_orphan |= orp_v[i];
            m_tmo    |= tmo_v[i];
        end
        pick = -1;
        for (int i = NID - 1; i >= 0; i--) if (tmo_v[i]) pick = i;
        for (int i = NID - 1; i >= 0; i--) if (dup_v[i]) pick = i;
        for (int i = NID - 1; i >= 0; i--) if (orp_v[i]) pick = i;
        if (pick >= 0) m_src = pick;
        m_sticky |= m_dup | m_orphan | m_tmo;
    endtask

    // Drive one cycle of inputs, advance model and DUT, compare all outputs
    task automatic cycle(input bit rst, input bit av, input bit ar, input int as, input int ab,
                         input bit dv, input bit dr, input int ds);
        reset_n  = rst;
        a_valid  = av;  a_ready = ar;
        a_source = SW'(as);
        a_beats  = BW'(ab);
        d_valid  = dv;  d_ready = dr;
        d_source = SW'(ds);
        model_step(rst, av && ar, as, ab, dv && dr, ds);
        @(posedge clock);
        #1;
        check("inflight",     32'(inflight),     32'(model_inflight()));
        check("err_dup_a",    32'(err_dup_a),    32'(m_dup));
        check("err_orphan_d", 32'(err_orphan_d), 32'(m_orphan));
        check("err_timeout",  32'(err_timeout),  32'(m_tmo));
        check("err_sticky",   32'(err_sticky),   32'(m_sticky));
        check("err_source",   32'(err_source),   32'(m_src));
    endtask

    task automatic idle();
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic send_a(input int src, input int beats);
        cycle(1, 1, 1, src, beats, 0, 0, 0);
    endtask

    task automatic send_d(input int src);
        cycle(1, 0, 0, 0, 0, 1, 1, src);
    endtask

    initial begin
        int tmo_seen;
        int tmo_at;
        reset_n = 0;
        a_valid = 0; a_ready = 0; a_source = '0; a_beats = '0;
        d_valid = 0; d_ready = 0; d_source = '0;

        // Reset state
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 1, 1, 2, 0, 0, 0);
        check("reset_inflight", 32'(inflight), 32'h0);
        check("reset_sticky",   32'(err_sticky), 32'h0);
        idle();

        // Single-beat request on ID 0
        send_a(0, 0);
        check("single_inflight_set", 32'(inflight), 32'h1);
        send_d(0);
        check("single_inflight_clr", 32'(inflight), 32'h0);
        check("single_no_err", 32'(err_sticky), 32'h0);

        // Four-beat request on ID 1
        send_a(1, 3);
        for (int k = 0; k < 3; k++) send_d(1);
        check("burst_still_pending", 32'(inflight), 32'h2);
        send_d(1);
        check("burst_done", 32'(inflight), 32'h0);

        // Duplicate A on ID 0
        send_a(0, 1);
        send_a(0, 1);
        check("dup_pulse",  32'(err_dup_a),  32'h1);
        check("dup_source", 32'(err_source), 32'h0);
        check("dup_sticky", 32'(err_sticky), 32'h1);
        idle();
        check("dup_one_cycle", 32'(err_dup_a), 32'h0);
        send_d(0);
        send_d(0);

        // Orphan D on idle ID 1
        send_d(1);
        check("orphan_pulse",    32'(err_orphan_d), 32'h1);
        check("orphan_source",   32'(err_source),   32'h1);
        check("orphan_inflight", 32'(inflight),     32'h0);

        // Final D and new A on the same ID in one cycle
        send_a(0, 0);
        cycle(1, 1, 1, 0, 1, 1, 1, 0);
        check("reuse_inflight", 32'(inflight), 32'h1);
        check("reuse_no_dup",   32'(err_dup_a), 32'h0);
        send_d(0);
        send_d(0);

        // Valid without ready is ignored
        cycle(1, 1, 0, 1, 0, 1, 0, 1);
        check("no_ready_inflight", 32'(inflight), 32'h0);

        // Watchdog on a stalled request
        send_a(0, 0);
        tmo_seen = 0;
        tmo_at   = -1;
        for (int k = 1; k <= 14; k++) begin
            idle();
            if (err_timeout) begin
                tmo_seen++;
                if (tmo_at < 0) tmo_at = k;
            end
        end
`ifdef TL_TRACKER_WATCHDOG_EN
        check("timeout_count", 32'(tmo_seen), 32'd1);
        check("timeout_cycle", 32'(tmo_at),   32'(TO));
`else
        check("timeout_count", 32'(tmo_seen), 32'd0);
`endif
        send_d(0);

        // Mid-operation reset discards outstanding state
        send_a(1, 3);
        send_d(1);
        cycle(0, 1, 1, 0, 0, 1, 1, 1);
        check("midreset_inflight", 32'(inflight), 32'h0);
        check("midreset_sticky",   32'(err_sticky), 32'h0);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            cycle(($urandom_range(0, 59) != 0),
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) != 0),
                  int'($urandom_range(0, NID - 1)), int'($urandom_range(0, 2**BW - 1)),
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) != 0),
                  int'($urandom_range(0, NID - 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tl_inflight_tracker.md
TL_INFLIGHT_TRACKER -- requirements
Module: tl_inflight_tracker

Interface
REQ-001 Parameter SOURCE_W, default 1: TileLink source-ID width; the block tracks 2^SOURCE_W IDs.
REQ-002 Parameter BEAT_W, default 2: D-beat counter width; a response carries at most 2^BEAT_W beats.
REQ-003 Parameter TIMEOUT, default 255: watchdog limit in cycles; valid range 1 to 65535.
REQ-004 clock  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 a_valid, a_ready  in  1 each  A-channel handshake; A fires when both are 1.
REQ-007 a_source  in  SOURCE_W  source ID of the A request.
REQ-008 a_beats  in  BEAT_W  expected D beats minus one.
REQ-009 d_valid, d_ready  in  1 each  D-channel handshake; D fires when both are 1.
REQ-010 d_source  in  SOURCE_W  source ID of the D beat.
REQ-011 inflight  out  2^SOURCE_W  per-ID outstanding bitmap.
REQ-012 err_dup_a  out  1  registered pulse: A fired on an ID that was already outstanding.
REQ-013 err_orphan_d  out  1  registered pulse: D fired on an ID that was idle.
REQ-014 err_timeout  out  1  registered pulse: an ID exceeded TIMEOUT.
REQ-015 err_sticky  out  1  OR of all error pulses, held until reset.
REQ-016 err_source  out  SOURCE_W  ID of the most recent error; priority is orphan, then dup, then timeout (lowest ID first).

Function
REQ-017 Each ID SHALL have an FSM with states IDLE and PEND, plus a beat counter (BEAT_W bits) and a beats-remaining register.
REQ-018 When A fires on an IDLE ID: go to PEND, load remaining=a_beats, clear the beat counter.
REQ-019 When A fires on a PEND ID: raise err_dup_a; state and counters unchanged.
REQ-020 When D fires on a PEND ID with counter<remaining: increment the counter.
REQ-021 When D fires on a PEND ID with counter==remaining: return to IDLE.
REQ-022 When D fires on an IDLE ID: raise err_orphan_d; state unchanged.
REQ-023 Same cycle, same ID, final D beat plus A: the ID SHALL stay in PEND with freshly loaded counters; no error.
REQ-024 Same cycle, same ID, non-final D beat plus A: err_dup_a fires and the D beat is counted.
REQ-025 Same cycle, different IDs: each ID updates independently.
REQ-026 inflight[i] SHALL be 1 exactly when ID i is in PEND, visible the cycle after the firing handshake.
REQ-027 Error pulses SHALL be asserted for one cycle, one cycle after the offending handshake.
REQ-028 Valid without ready SHALL cause no state change.

Reset
REQ-029 While reset_n==0 at a clock edge: all IDs go to IDLE, counters clear, and every output is driven to 0 on the next cycle.
REQ-030 A handshake sampled during reset SHALL be ignored, and a mid-operation reset SHALL discard all outstanding state.

Configuration
REQ-031 With TL_TRACKER_WATCHDOG_EN defined:
- each ID has a 16-bit age counter, cleared on entering PEND and on every D beat, and incremented while in PEND;
- when the counter reaches TIMEOUT, err_timeout pulses once and the counter saturates until the next D beat or IDLE.
REQ-032 Without TL_TRACKER_WATCHDOG_EN: no age counters are built and err_timeout is tied to 0.

Structure
REQ-033 Shared package tl_tracker_pkg SHALL hold the FSM state enum (IDLE, PEND) and the error-priority constants.
REQ-034 Sub-module tl_inflight_slot implements one ID (FSM, beat counter, optional age counter); the top instantiates 2^SOURCE_W slots and encodes the errors.

Verification
REQ-035 A fires src 0 with a_beats=0, then D src 0 one cycle later -> inflight 01, then 00; no errors.
REQ-036 A fires src 1 with a_beats=3, then 4 D beats src 1 -> inflight[1] clears only after the 4th beat.
REQ-037 A src 0 twice with no D between -> err_dup_a=1 for one cycle, err_source=0, err_sticky=1.
REQ-038 D src 1 while idle -> err_orphan_d pulse, err_source=1; inflight unchanged.
REQ-039 Final D src 0 and new A src 0 in the same cycle -> inflight[0] stays 1 and no error pulses.
REQ-040 With macro on, TIMEOUT=8: A src 0 with no D -> err_timeout pulses once, 8 cycles after inflight rises. With macro off -> err_timeout never asserts.
